fib_matpow_seq: RTL and testbench

Multi-cycle Fibonacci engine built on 2x2 matrix fast exponentiation. It accepts an index n over a valid/ready handshake and returns F(n) mod 2^WIDTH over a second valid/ready handshake. It is the sequential, pipelinable counterpart of the combinational `source` Fibonacci unit (32-bit in -> 32-bit out), and drives the same downstream consumers. One 2x2 matrix product is evaluated per cycle, so the critical path stays bounded.

---
 rtl/fib_pkg.sv | 16 +
 rtl/mat2_mul.sv | 23 ++
 rtl/fib_matpow_seq.sv | 96 +++++++++
 tb/tb_fib_matpow_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the matrix-power Fibonacci engine.
package fib_pkg;

   localparam int unsigned FIB_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } state_t;

   // 2x2 matrices of 0/1 elements, bit k holds element (row, col) with k = 2*row + col
   localparam logic [3:0] MAT_I_BITS = 4'b1001;   // identity
   localparam logic [3:0] MAT_M_BITS = 4'b0111;   // [[1,1],[1,0]]

endpackage

// File: rtl/mat2_mul.sv
// Combinational 2x2 by 2x2 matrix product, all arithmetic wrapping mod 2^WIDTH.
// Element k of each flattened matrix is (row, col) with k = 2*row + col.
module mat2_mul #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [3:0][WIDTH-1:0] a,
   input  logic [3:0][WIDTH-1:0] b,
   output logic [3:0][WIDTH-1:0] prod_c
);

   // C[i][j] = A[i][0]*B[0][j] + A[i][1]*B[1][j], each term truncated to WIDTH bits
   for (genvar i = 0; i < 2; i++) begin : g_row
      for (genvar j = 0; j < 2; j++) begin : g_col
         localparam int unsigned K  = 2 * i + j;
         localparam int unsigned A0 = 2 * i;
         localparam int unsigned A1 = 2 * i + 1;
         localparam int unsigned B0 = j;
         localparam int unsigned B1 = 2 + j;
         assign prod_c[K] = WIDTH'(a[A0] * b[B0]) + WIDTH'(a[A1] * b[B1]);
      end
   end

endmodule

// File: rtl/fib_matpow_seq.sv
// Sequential Fibonacci engine: F(n) mod 2^WIDTH via square-and-multiply of [[1,1],[1,0]].
// One matrix product per STEP cycle; result returned over a valid/ready handshake.
module fib_matpow_seq
   import fib_pkg::*;
#(
   parameter int unsigned WIDTH = FIB_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] n,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] fib,
   output logic             busy
);

   state_t                 state_q;
   logic [3:0][WIDTH-1:0]  r_q;
   logic [3:0][WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]       e_q;
   logic [3:0][WIDTH-1:0]  mat_i;
   logic [3:0][WIDTH-1:0]  mat_m;
   logic [3:0][WIDTH-1:0]  op_a_c;
   logic [3:0][WIDTH-1:0]  prod_c;

   // Widen the 0/1 constant matrices to the datapath width
   for (genvar k = 0; k < 4; k++) begin : g_const
      assign mat_i[k] = WIDTH'(MAT_I_BITS[k]);
      assign mat_m[k] = WIDTH'(MAT_M_BITS[k]);
   end

   // Odd exponent multiplies the result by the base; even exponent squares the base
   assign op_a_c = e_q[0] ? r_q : b_q;

   mat2_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .a      (op_a_c),
      .b      (b_q),
      .prod_c (prod_c)
   );

   // FSM, matrix/exponent registers and registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         r_q       <= mat_i;
         b_q       <= mat_m;
         e_q       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         fib       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready) begin
                  r_q      <= mat_i;
                  b_q      <= mat_m;
                  e_q      <= n;
                  state_q  <= STEP;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            STEP: begin
               if (e_q == '0) begin
                  state_q   <= DONE;
                  fib       <= r_q[1];
                  out_valid <= 1'b1;
               end else if (e_q[0]) begin
                  r_q    <= prod_c;
                  e_q[0] <= 1'b0;
               end else begin
                  b_q <= prod_c;
                  e_q <= e_q >> 1;
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  state_q   <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fib_matpow_seq.sv
// Bench for fib_matpow_seq: directed steps plus random throttled traffic,
// checked against a fast-doubling Fibonacci model through an in-order scoreboard.
module tb_fib_matpow_seq;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] n;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] fib;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit throttle = 0;
   bit ov_prev  = 0;

   typedef struct {
      logic [31:0] n;
      logic [31:0] fib;
      int          s;
      int          t;
   } exp_t;

   exp_t q[$];

   fib_matpow_seq #(
      .WIDTH (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .n         (n),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fib       (fib),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Fast-doubling reference: F(2k)=F(k)(2F(k+1)-F(k)), F(2k+1)=F(k)^2+F(k+1)^2
   function automatic logic [31:0] fib_ref(input logic [31:0] v);
      logic [31:0] a, b, c, d;
      a = 32'd0;
      b = 32'd1;
      for (int i = 31; i >= 0; i--) begin
         c = a * ((b << 1) - a);
         d = a * a + b * b;
         if (v[i]) begin
            a = d;
            b = c + d;
         end else begin
            a = c;
            b = d;
         end
      end
      return a;
   endfunction

   // Expected STEP cycle count: popcount + max(bitlen-1, 0) + 1
   function automatic int s_ref(input logic [31:0] v);
      int pc, bl;
      pc = 0;
      bl = 0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) begin
            pc++;
            bl = i + 1;
         end
      end
      return pc + ((bl > 0) ? bl - 1 : 0) + 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor, sampling on the falling edge
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         ov_prev = 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            exp_t e;
            e.n   = n;
            e.fib = fib_ref(n);
            e.s   = s_ref(n);
            e.t   = cyc + 1;
            q.push_back(e);
         end
         if (out_valid && !ov_prev) begin
            if (q.size() == 0) check("spurious_out_valid", 32'd1, 32'd0);
            else check("latency", 32'(cyc - q[0].t), 32'(q[0].s));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_result", fib, 32'hxxxx_xxxx);
            end else begin
               check("fib", fib, q[0].fib);
               void'(q.pop_front());
            end
         end
         ov_prev = out_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (throttle) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Present v until accepted; returns just after the accepting edge
   task automatic send(input logic [31:0] v);
      bit acc;
      acc = 1'b0;
      in_valid = 1'b1;
      n = v;
      for (int k = 0; k < 300; k++) begin
         acc = in_ready;
         tick();
         if (acc) break;
      end
      in_valid = 1'b0;
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input int bound);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         if (q.size() == 0 && in_ready && !out_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) check("idle_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      n = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;

      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fib", fib, 32'd0);

      // n=0: busy right after accept, result and return to idle
      send(32'd0);
      check("n0_busy", 32'(busy), 32'd1);
      check("n0_in_ready", 32'(in_ready), 32'd0);
      wait_idle(100);
      check("n0_fib", fib, 32'd0);
      check("n0_idle_busy", 32'(busy), 32'd0);

      send(32'd1);  wait_idle(100); check("n1_fib", fib, 32'd1);
      send(32'd5);  wait_idle(100); check("n5_fib", fib, 32'd5);
      send(32'd10); wait_idle(100); check("n10_fib", fib, 32'd55);
      send(32'd47); wait_idle(200); check("n47_fib", fib, 32'hB11924E1);
      send(32'd48); wait_idle(200); check("n48_fib", fib, 32'h1E8D0A40);
      send(32'hFFFF_FFFF); wait_idle(200);
      check("nmax_fib", fib, fib_ref(32'hFFFF_FFFF));

      // Backpressure: result held, new requests ignored
      out_ready = 1'b0;
      send(32'd10);
      for (int k = 0; k < 50 && !out_valid; k++) tick();
      check("bp_out_valid_rise", 32'(out_valid), 32'd1);
      for (int k = 0; k < 7; k++) begin
         in_valid = k[0];
         n = 32'd3;
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_fib", fib, 32'd55);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_busy", 32'(busy), 32'd1);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      send(32'd7); wait_idle(100); check("n7_fib", fib, 32'd13);

      // Reset in the third STEP cycle of n=40
      send(32'd40);
      tick();
      tick();
      check("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_fib", fib, 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      send(32'd12); wait_idle(100); check("n12_fib", fib, 32'd144);

      // Random traffic with throttled valid and ready
      throttle = 1'b1;
      for (int v = 0; v < 1000; v++) begin
         logic [31:0] rn;
         rn = $urandom();
         if ($urandom_range(0, 1) == 0) rn = rn & 32'h0000_00FF;
         repeat ($urandom_range(0, 2)) tick();
         send(rn);
      end
      wait_idle(500);
      throttle = 1'b0;
      out_ready = 1'b1;
      check("queue_drained", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
